systolic_seq_ctrl: RTL
======================

// Module: systolic_seq_ctrl
// PURPOSE
//   Sequencer for the N1xN2 output-stationary systolic array. On start it streams
//   num_tiles tiles of k_len operand vectors from the A/B operand buffers, applies
//   diagonal skew (row i / column j delayed i / j cycles), and drives the per-PE init
//   wavefront marking k=0 of each tile. It then drains the array and pulses done.
//   Sits between the operand buffers and the systolic array's A, B and init inputs.
// PARAMETERS
//   D_W     8   operand width
//   N1      8   array rows (A lanes)
//   N2      4   array columns (B lanes)
//   K_W     8   width of k_len
//   T_W     8   width of num_tiles
//   ADDR_W  16  operand-buffer address width
//   PE_LAT  2   PE accumulate-to-output latency, counted into drain
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous reset, active-high
//   start      in   1          begin run; sampled only in IDLE
//   k_len      in   K_W        vectors per tile; sampled with start
//   num_tiles  in   T_W        tiles per run; sampled with start
//   busy       out  1          high in any state except IDLE
//   done       out  1          one-cycle pulse at end of run
//   a_rd_en    out  1          A buffer read strobe
//   a_rd_addr  out  ADDR_W     A buffer address; one N1*D_W word per k
//   a_rd_data  in   N1*D_W     A read data, valid 1 cycle after a_rd_en
//   b_rd_en    out  1          B buffer read strobe, identical to a_rd_en
//   b_rd_addr  out  ADDR_W     B buffer address, equals a_rd_addr
//   b_rd_data  in   N2*D_W     B read data, valid 1 cycle after b_rd_en
//   A          out  N1*D_W     skewed A lanes to array
//   B          out  N2*D_W     skewed B lanes to array
//   init       out  N1*N2      per-PE init, bit i*N2+j for PE(i,j)
// BEHAVIOUR
//   Reset: all state/outputs 0 (FSM=IDLE, busy=done=rd_en=0, addr=0, A=B=init=0).
//   FSM: IDLE -start-> FEED -last read-> DRAIN -cnt=0-> DONE -> IDLE.
//     IDLE: start with k_len==0 or num_tiles==0 -> DONE directly; no reads, no init.
//     FEED: exactly num_tiles*k_len cycles, rd_en=1 every cycle, addr 0,1,2,...
//       contiguous across tiles; k_cnt wraps k_len-1->0 and increments tile_cnt.
//     DRAIN: counter loaded with N1+N2+PE_LAT+1 (the +1 covers the A/B/init
//       output register stage); rd_en=0; skew pipes keep shifting.
//     DONE: done=1, busy=1 for one cycle; next cycle IDLE, busy=0.
//   Skew: read data word k (read issued at FEED cycle F0+k) appears on A lane i at
//     cycle F0+2+k+i and on B lane j at F0+2+k+j (1 buffer + 1 output register + lane
//     delay). Lane slots carrying no read data are driven 0.
//   init: for tile t, bit (i,j) high for exactly one cycle at F0+2+t*k_len+i+j.
//     All other cycles 0. With k_len==1, consecutive tiles pulse every cycle per PE.
//   start while busy: ignored; k_len/num_tiles changes while busy: ignored.
//   Reset mid-run: immediate abort, skew pipes cleared, no done pulse.
//   Address counter width ADDR_W; caller guarantees num_tiles*k_len <= 2^ADDR_W.
// TESTING
//   1 rst held, then released, no start -> busy=done=rd_en=0, A=B=init=0 for 20 cycles.
//   2 N1=8,N2=4,k_len=4,num_tiles=1 -> rd addr 0..3 on cycles F0..F0+3; A lane 7
//     word0 at F0+9; init bit 31 at F0+12 only; done at F0+4+16 (F0+20).
//   3 k_len=3,num_tiles=2 -> addr 0..5 contiguous; init bit 0 at F0+2 and F0+5,
//     bit 31 at F0+12 and F0+15; exactly one done pulse.
//   4 start with k_len=0 (num_tiles=5) -> DONE next cycle, done pulse, no rd_en,
//     init stays 0.
//   5 start re-pulsed mid-FEED with new k_len -> ignored; original address
//     sequence and done timing unchanged.
//   6 rst asserted at FEED cycle F0+2 -> same-cycle outputs 0, busy=0, no done;
//     a following start runs cleanly from addr 0.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: streams tiles of A/B operand vectors into an N1xN2 systolic array
// with diagonal skew and per-PE init wavefront, then drains and pulses done.
module systolic_seq_ctrl #(
    parameter int D_W    = 8,
    parameter int N1     = 8,
    parameter int N2     = 4,
    parameter int K_W    = 8,
    parameter int T_W    = 8,
    parameter int ADDR_W = 16,
    parameter int PE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    input  logic [T_W-1:0]       num_tiles,
    output logic                 busy,
    output logic                 done,
    output logic                 a_rd_en,
    output logic [ADDR_W-1:0]    a_rd_addr,
    input  logic [N1*D_W-1:0]    a_rd_data,
    output logic                 b_rd_en,
    output logic [ADDR_W-1:0]    b_rd_addr,
    input  logic [N2*D_W-1:0]    b_rd_data,
    output logic [N1*D_W-1:0]    A,
    output logic [N2*D_W-1:0]    B,
    output logic [N1*N2-1:0]     init
);
    localparam int DR   = N1 + N2 + PE_LAT + 1;
    localparam int DC_W = $clog2(DR + 1);
    localparam int IPW  = N1 + N2 - 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_len_q, k_len_d;
    logic [T_W-1:0]    nt_q, nt_d;
    logic [K_W-1:0]    k_cnt_q, k_cnt_d;
    logic [T_W-1:0]    t_cnt_q, t_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic              vld_q, vld_d;
    logic              kz_q, kz_d;
    logic [IPW-1:0]    ip_q, ip_d;
    logic              last_k;

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        nt_d    = nt_q;
        k_cnt_d = k_cnt_q;
        t_cnt_d = t_cnt_q;
        addr_d  = addr_q;
        dcnt_d  = dcnt_q;
        last_k  = k_cnt_q == k_len_q - K_W'(1);
        vld_d   = state_q == S_FEED;
        kz_d    = state_q == S_FEED && k_cnt_q == '0;
        ip_d    = IPW'({ip_q, kz_q});
        case (state_q)
            S_IDLE: if (start) begin
                k_len_d = k_len;
                nt_d    = num_tiles;
                k_cnt_d = '0;
                t_cnt_d = '0;
                addr_d  = '0;
                state_d = (k_len == '0 || num_tiles == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                addr_d  = addr_q + ADDR_W'(1);
                k_cnt_d = last_k ? '0 : k_cnt_q + K_W'(1);
                t_cnt_d = last_k ? t_cnt_q + T_W'(1) : t_cnt_q;
                if (last_k && t_cnt_q == nt_q - T_W'(1)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = DC_W'(DR);
                end
            end
            S_DRAIN: begin
                dcnt_d  = dcnt_q - DC_W'(1);
                state_d = dcnt_q == '0 ? S_DONE : S_DRAIN;
            end
            default: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
            nt_q    <= '0;
            k_cnt_q <= '0;
            t_cnt_q <= '0;
            addr_q  <= '0;
            dcnt_q  <= '0;
            vld_q   <= 1'b0;
            kz_q    <= 1'b0;
            ip_q    <= '0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            nt_q    <= nt_d;
            k_cnt_q <= k_cnt_d;
            t_cnt_q <= t_cnt_d;
            addr_q  <= addr_d;
            dcnt_q  <= dcnt_d;
            vld_q   <= vld_d;
            kz_q    <= kz_d;
            ip_q    <= ip_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign a_rd_en   = state_q == S_FEED;
    assign b_rd_en   = a_rd_en;
    assign a_rd_addr = addr_q;
    assign b_rd_addr = addr_q;

    // Lane i holds i+1 stages: the output register plus i cycles of skew.
    for (genvar i = 0; i < N1; i++) begin : g_a
        logic [(i+1)*D_W-1:0] sr_q, sr_d;
        always_comb sr_d = ((i+1)*D_W)'({sr_q, vld_q ? a_rd_data[i*D_W +: D_W] : D_W'(0)});
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sr_q <= '0;
            else     sr_q <= sr_d;
        end
        assign A[i*D_W +: D_W] = sr_q[(i+1)*D_W-1 -: D_W];
    end

    for (genvar j = 0; j < N2; j++) begin : g_b
        logic [(j+1)*D_W-1:0] sr_q, sr_d;
        always_comb sr_d = ((j+1)*D_W)'({sr_q, vld_q ? b_rd_data[j*D_W +: D_W] : D_W'(0)});
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sr_q <= '0;
            else     sr_q <= sr_d;
        end
        assign B[j*D_W +: D_W] = sr_q[(j+1)*D_W-1 -: D_W];
    end

    // PE(i,j) sees the k=0 marker after i+j cycles of wavefront delay.
    always_comb begin
        init = '0;
        for (int i = 0; i < N1; i++)
            for (int j = 0; j < N2; j++)
                init[i*N2+j] = ip_q[i+j];
    end
endmodule
